// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - multi-cycle 16-bit shift/rotate unit, two bit positions per cycle
module iterative_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [1:0]       op_q,    op_d;

    // One step of the current operation: by two positions, or by one when only one remains.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                              input logic [1:0]       op,
                                              input logic             two);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_ROL:  r = two ? {d[WIDTH-3:0], d[WIDTH-1:WIDTH-2]} : {d[WIDTH-2:0], d[WIDTH-1]};
            OP_SLL:  r = two ? {d[WIDTH-3:0], 2'b00}              : {d[WIDTH-2:0], 1'b0};
            OP_ROR:  r = two ? {d[1:0], d[WIDTH-1:2]}             : {d[0], d[WIDTH-1:1]};
            OP_SRL:  r = two ? {2'b00, d[WIDTH-1:2]}              : {1'b0, d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic: capture in IDLE, step in BUSY, hold until handoff in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = In;
                    rem_d   = Cnt;
                    op_d    = Op;
                    state_d = (Cnt != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (rem_q >= CNT_W'(2)) begin
                    data_d = step(data_q, op_q, 1'b1);
                    rem_d  = rem_q - CNT_W'(2);
                end else begin
                    data_d = step(data_q, op_q, 1'b0);
                    rem_d  = '0;
                end
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Out       = data_q;

endmodule
